// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the modulo-N counter.
//   DEFAULT_N     - default modulus (count sequence 0..N-1)
//   DEFAULT_WIDTH - default width of the count value
//   MIN_N / MAX_N - legal modulus range
package counter_pkg;
  localparam int DEFAULT_N     = 6;
  localparam int DEFAULT_WIDTH = 3;
  localparam int MIN_N         = 2;
  localparam int MAX_N         = 8;
endpackage

// File: rtl/counter_n_if.sv
// counter_n_if: groups the counter's enable / carry / count signals.
//   enable      - count enable, sampled on the rising clock edge
//   carry_out_N - combinational terminal-count carry (enable && count_N == N-1)
//   count_N     - registered count value
// Handshake: there is no back-pressure. enable acts as a one-way valid, and
// the counter is always ready. An edge with enable=1 advances the count.
// carry_out_N may feed the next stage's enable for cascading.
// modport master drives enable. modport slave is the counter itself.
interface counter_n_if #(
  parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
);
  logic             enable;
  logic             carry_out_N;
  logic [WIDTH-1:0] count_N;

  modport master (output enable, input carry_out_N, input count_N);
  modport slave  (input enable, output carry_out_N, output count_N);
endinterface

// File: rtl/counter_n.sv
// counter_n: modulo-N up-counter with enable and a cascadable carry.
//   clk   - rising-edge clock
//   reset - asynchronous, active-low (0 = reset asserted, count_N forced to 0)
//   bus   - counter_n_if.slave: enable in, carry_out_N and count_N out
// Parameters: N (modulus, 2..8) and WIDTH (count width, N <= 2**WIDTH).
module counter_n
  import counter_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  counter_n_if.slave   bus
);

  // Parameter legality. These checks are evaluated at elaboration and
  // produce no hardware.
  if (N < MIN_N || N > MAX_N) begin : g_bad_n
    $error("counter_n: N=%0d outside legal range %0d..%0d", N, MIN_N, MAX_N);
  end
  if (N > (1 << WIDTH)) begin : g_bad_width
    $error("counter_n: N=%0d does not fit in WIDTH=%0d bits", N, WIDTH);
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             carry;

  // The next-state logic and the carry are in one block.
  // The ">=" test covers the normal wrap at N-1. It also covers any
  // unreachable value >= N, so such a value loads 0 and never runs past N-1.
  always_comb begin
    count_d = count_q;
    carry   = 1'b0;
    if (bus.enable) begin
      carry = (count_q == LAST);
      if (count_q >= LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.count_N     = count_q;
  assign bus.carry_out_N = carry;

endmodule

// File: tb/tb_counter_n.sv
// tb_counter_n: directed self-checking bench for counter_n.
// Two instances share the clock and reset. u_dut6 has N=6. u_dut8 has N=8,
// which exercises the full-modulus wrap in 3 bits.
`timescale 1ns/1ps
module tb_counter_n;
  import counter_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  counter_n_if #(.WIDTH(3)) if6 ();
  counter_n_if #(.WIDTH(3)) if8 ();

  counter_n #(.N(6), .WIDTH(3)) u_dut6 (.clk(clk), .reset(reset), .bus(if6.slave));
  counter_n #(.N(8), .WIDTH(3)) u_dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

  // Clock and reset: 4 ns period. Reset is asserted at time 0.
  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for a rising edge, then moves 1 ns past it. Inputs are driven and
  // outputs are sampled there, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp6;
  int exp8;

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    reset      = 1'b0;
    if6.enable = 1'b0;
    if8.enable = 1'b0;
    #1;
    check("reset_count6", int'(if6.count_N), 0);
    check("reset_carry6", int'(if6.carry_out_N), 0);
    check("reset_count8", int'(if8.count_N), 0);

    // Reset held while enable toggles. Count and carry must stay 0.
    for (int i = 0; i < 10; i++) begin
      if6.enable = i[0];
      #0.5;
      check("rst_hold_carry", int'(if6.carry_out_N), 0);
      tick();
      check("rst_hold_count", int'(if6.count_N), 0);
    end

    // Release reset between edges with enable low. The count must not move.
    if6.enable = 1'b0;
    reset      = 1'b1;
    #1;
    check("release_count", int'(if6.count_N), 0);

    // Basic count with N=6: 1,2,3,4,5,0,1. Carry is 1 only while count is 5.
    tick();
    if6.enable = 1'b1;
    exp6 = 0;
    for (int i = 0; i < 7; i++) begin
      check("basic_carry", int'(if6.carry_out_N), (exp6 == 5) ? 1 : 0);
      tick();
      exp6 = (exp6 == 5) ? 0 : exp6 + 1;
      check("basic_count", int'(if6.count_N), exp6);
    end
    check("basic_end", int'(if6.count_N), 1);

    // Hold: advance to 3, drop enable for 5 cycles, then resume to 4.
    tick();
    tick();
    check("hold_reach3", int'(if6.count_N), 3);
    if6.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_count", int'(if6.count_N), 3);
    end
    if6.enable = 1'b1;
    tick();
    check("hold_resume", int'(if6.count_N), 4);

    // Carry gating at count 5.
    tick();
    check("gate_at5", int'(if6.count_N), 5);
    check("gate_carry_on", int'(if6.carry_out_N), 1);
    if6.enable = 1'b0;
    #0.5;
    check("gate_carry_off", int'(if6.carry_out_N), 0);
    tick();
    check("gate_hold5", int'(if6.count_N), 5);
    if6.enable = 1'b1;
    #0.5;
    check("gate_carry_back", int'(if6.carry_out_N), 1);
    tick();
    check("gate_wrap", int'(if6.count_N), 0);

    // Asynchronous reset between edges at count 4.
    for (int i = 0; i < 4; i++) tick();
    check("arst_at4", int'(if6.count_N), 4);
    reset = 1'b0;
    #1;
    check("arst_count", int'(if6.count_N), 0);
    check("arst_carry", int'(if6.carry_out_N), 0);
    reset = 1'b1;
    tick();
    check("arst_resume1", int'(if6.count_N), 1);
    tick();
    check("arst_resume2", int'(if6.count_N), 2);

    // Full modulus with N=8: 1..7 then 0. Carry is 1 only while count is 7.
    // u_dut8 has not counted yet, because its enable has stayed low.
    if6.enable = 1'b0;
    if8.enable = 1'b1;
    exp8 = 0;
    #0.5;
    check("n8_start", int'(if8.count_N), 0);
    for (int i = 0; i < 9; i++) begin
      check("n8_carry", int'(if8.carry_out_N), (exp8 == 7) ? 1 : 0);
      tick();
      exp8 = (exp8 + 1) % 8;
      check("n8_count", int'(if8.count_N), exp8);
    end
    check("n8_end", int'(if8.count_N), 1);
    if8.enable = 1'b0;
    #0.5;
    check("n8_carry_idle", int'(if8.carry_out_N), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/counter_n.md
COUNTER_N -- requirements
Module: counter_n

Interface
REQ-001 Parameter N, default 6, modulus: count sequence 0..N-1; legal range 2..8.
REQ-002 Parameter WIDTH, default 3, width of count_N; the block SHALL require N <= 2**WIDTH.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 Port enable, input, 1, count enable, sampled on clk rising edge.
REQ-007 Port carry_out_N, output, 1, terminal-count carry for cascading.
REQ-008 Port count_N, output, WIDTH (3), current count value.

Function
REQ-009 count_N SHALL be a registered value updated only on the clk rising edge, or asynchronously by reset.
REQ-010 enable=1 at an edge with count_N < N-1 SHALL give count_N+1 after that edge (1-cycle latency).
REQ-011 enable=1 at an edge with count_N = N-1 SHALL wrap count_N to 0.
REQ-012 enable=0 at an edge SHALL hold count_N unchanged.
REQ-013 carry_out_N SHALL be combinational: 1 iff enable=1 and count_N = N-1, else 0.
REQ-014 carry_out_N SHALL fall in the same delta as enable falls, with no clock edge required.
REQ-015 If count_N >= N (unreachable), the next enabled edge SHALL load 0.
REQ-016 Arithmetic SHALL be unsigned WIDTH-bit with no overflow beyond N-1.
REQ-017 With N = 2**WIDTH, the natural wrap SHALL give the same sequence.

Reset
REQ-018 reset=0 SHALL force count_N=0 immediately, without waiting for a clock edge.
REQ-019 While reset=0, carry_out_N SHALL be 0 for N>1, because count_N=0 is not N-1.
REQ-020 reset SHALL take priority over enable.
REQ-021 A reset asserted mid-sequence SHALL abort the count.
REQ-022 Counting SHALL resume from 0 at the first rising edge with reset=1 and enable=1.
REQ-023 Reset release SHALL NOT itself change count_N.

Structure
REQ-024 Constants DEFAULT_N=6 and DEFAULT_WIDTH=3 SHALL live in a shared package, counter_pkg.
REQ-025 The block SHALL be a single module with no sub-modules.
REQ-026 The block SHALL contain one register process and one combinational next-state/carry block.
REQ-027 The block SHALL include parameter-legality checks on N and WIDTH that are elaborated but not synthesized.
REQ-028 Cascading SHALL be done by feeding carry_out_N into the next stage's enable.

Verification
Clock period 4 ns for all scenarios.
REQ-029 Reset held:
- reset=0, enable toggled 0->1 for 10 cycles -> count_N=0, carry_out_N=0 throughout.
REQ-030 Basic count, N=6:
- reset=1, enable=1 -> count_N 1,2,3,4,5,0,1 on successive edges.
- carry_out_N=1 exactly in the cycle where count_N=5.
REQ-031 Hold:
- enable dropped at count_N=3 for 5 cycles -> count_N stays 3.
- enable raised again -> next edge gives 4.
REQ-032 Carry gating:
- at count_N=5, enable=0 -> carry_out_N=0 immediately, count_N stays 5.
- enable=1 -> carry_out_N=1, next edge gives 0.
REQ-033 Asynchronous mid-count reset:
- reset driven 0 between edges at count_N=4 -> count_N=0 before the next edge.
- release with enable=1 -> 1,2,... from the next edge.
REQ-034 Full modulus, N=8:
- enable=1 -> 0..7 then 0.
- carry_out_N=1 only while count_N=7.
